decrypt_byte_serializer: RTL and testbench

//   Downstream stage of the decrypt core: captures each 4-byte plaintext word
//   (IN_1..IN_4) when the core strobes EN, buffers words in a small FIFO, and

---
 rtl/crypt_pkg.sv | 16 +
 rtl/word_fifo.sv | 62 ++++++
 rtl/decrypt_byte_serializer.sv | 123 ++++++++++++
 tb/tb_decrypt_byte_serializer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crypt_pkg.sv
// Shared definitions for the decrypt output path: byte/word geometry,
// the serializer state encoding and the buffered word type.
package crypt_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO with registered full flag and occupancy count.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module word_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = full_q;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_q || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/decrypt_byte_serializer.sv
// Buffers 4-byte plaintext words from the decrypt core and streams them out
// byte-by-byte (IN_1 first) over valid/ready, tracking an XOR checksum and word count.
module decrypt_byte_serializer #(
  parameter int DEPTH  = 4,
  parameter int BYTE_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [BYTE_W-1:0] IN_1,
  input  logic [BYTE_W-1:0] IN_2,
  input  logic [BYTE_W-1:0] IN_3,
  input  logic [BYTE_W-1:0] IN_4,
  output logic [BYTE_W-1:0] OUT_BYTE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              FULL,
  output logic              OVERFLOW,
  output logic [BYTE_W-1:0] CHKSUM,
  output logic [7:0]        WORD_CNT
);

  import crypt_pkg::*;

  localparam int         WW       = BYTES_PER_WORD * BYTE_W;
  localparam int         CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  state_t            state_q, state_d;
  logic [WW-1:0]     shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] chksum_q, chksum_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic              overflow_q;

  logic [WW-1:0]     fifo_dout;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              word_dropped;

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (EN),
    .data_i  ({IN_4, IN_3, IN_2, IN_1}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // The low byte of the shift register is always the byte on offer.
  assign OUT_BYTE     = shift_q[BYTE_W-1:0];
  assign OUT_VALID    = (state_q == SEND);
  assign FULL         = fifo_full;
  assign OVERFLOW     = overflow_q;
  assign CHKSUM       = chksum_q;
  assign WORD_CNT     = word_cnt_q;
  assign word_dropped = EN && (fifo_count == CNT_W'(DEPTH)) && !fifo_pop;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    chksum_d   = chksum_q;
    word_cnt_d = word_cnt_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          idx_d    = 2'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (OUT_READY) begin
          chksum_d = chksum_q ^ OUT_BYTE;
          if (idx_q == LAST_IDX) begin
            word_cnt_d = word_cnt_q + 8'd1;
            idx_d      = 2'd0;
            // Chain straight into the next buffered word to avoid a bubble.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_dout;
            end else begin
              shift_d = '0;
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + 2'd1;
            shift_d = shift_q >> BYTE_W;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= 2'd0;
      chksum_q   <= '0;
      word_cnt_q <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      chksum_q   <= chksum_d;
      word_cnt_q <= word_cnt_d;
      if (word_dropped) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decrypt_byte_serializer.sv
// Directed testbench for decrypt_byte_serializer: reset, latency, backpressure,
// back-to-back words, overflow and reset in the middle of a word.
module tb_decrypt_byte_serializer;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST, EN, OUT_READY;
  logic [7:0] IN_1, IN_2, IN_3, IN_4;
  logic [7:0] OUT_BYTE, CHKSUM, WORD_CNT;
  logic       OUT_VALID, FULL, OVERFLOW;

  int checks = 0;
  int errors = 0;

  decrypt_byte_serializer #(
    .DEPTH  (DEPTH),
    .BYTE_W (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .IN_1      (IN_1),
    .IN_2      (IN_2),
    .IN_3      (IN_3),
    .IN_4      (IN_4),
    .OUT_BYTE  (OUT_BYTE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .FULL      (FULL),
    .OVERFLOW  (OVERFLOW),
    .CHKSUM    (CHKSUM),
    .WORD_CNT  (WORD_CNT)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    RST = 1'b1; EN = 1'b0; OUT_READY = 1'b0;
    IN_1 = 8'h00; IN_2 = 8'h00; IN_3 = 8'h00; IN_4 = 8'h00;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    EN = 1'b1; IN_1 = b0; IN_2 = b1; IN_3 = b2; IN_4 = b3;
    @(negedge CLK);
    EN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({OUT_BYTE, OUT_VALID, FULL, OVERFLOW, CHKSUM, WORD_CNT} !== 28'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got byte=%h valid=%b full=%b ovf=%b chk=%h cnt=%h, want all 0",
               OUT_BYTE, OUT_VALID, FULL, OVERFLOW, CHKSUM, WORD_CNT);
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle_valid[%0d]: got %b want 0", i, OUT_VALID);
      end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    OUT_READY = 1'b1;
    push_word(8'h11, 8'h22, 8'h33, 8'h44);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_latency: valid got %b want 0 one edge after EN", OUT_VALID);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, OUT_BYTE} !== {1'b1, exp[i]}) begin
        errors++;
        $display("[TB] FAIL single_byte[%0d]: got valid=%b byte=%h want valid=1 byte=%h",
                 i, OUT_VALID, OUT_BYTE, exp[i]);
      end
    end
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, CHKSUM, WORD_CNT} !== {1'b0, 8'h44, 8'h01}) begin
      errors++;
      $display("[TB] FAIL single_end: got valid=%b chk=%h cnt=%h want valid=0 chk=44 cnt=01",
               OUT_VALID, CHKSUM, WORD_CNT);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [7];
    logic       rdy [7];
    exp = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
    rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    OUT_READY = 1'b1;
    push_word(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge CLK);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({OUT_VALID, OUT_BYTE} !== {1'b1, exp[i]}) begin
        errors++;
        $display("[TB] FAIL bp_byte[%0d]: got valid=%b byte=%h want valid=1 byte=%h",
                 i, OUT_VALID, OUT_BYTE, exp[i]);
      end
      OUT_READY = rdy[i];
      @(negedge CLK);
    end
    checks++;
    if ({OUT_VALID, CHKSUM, WORD_CNT} !== {1'b0, 8'h44, 8'h01}) begin
      errors++;
      $display("[TB] FAIL bp_end: got valid=%b chk=%h cnt=%h want valid=0 chk=44 cnt=01",
               OUT_VALID, CHKSUM, WORD_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    OUT_READY = 1'b1;
    EN = 1'b1; IN_1 = 8'h11; IN_2 = 8'h22; IN_3 = 8'h33; IN_4 = 8'h44;
    @(negedge CLK);
    IN_1 = 8'h55; IN_2 = 8'h66; IN_3 = 8'h77; IN_4 = 8'h88;
    @(negedge CLK);
    EN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({OUT_VALID, OUT_BYTE} !== {1'b1, exp[i]}) begin
        errors++;
        $display("[TB] FAIL b2b_byte[%0d]: got valid=%b byte=%h want valid=1 byte=%h",
                 i, OUT_VALID, OUT_BYTE, exp[i]);
      end
      @(negedge CLK);
    end
    checks++;
    if ({OUT_VALID, CHKSUM, WORD_CNT} !== {1'b0, 8'h88, 8'h02}) begin
      errors++;
      $display("[TB] FAIL b2b_end: got valid=%b chk=%h cnt=%h want valid=0 chk=88 cnt=02",
               OUT_VALID, CHKSUM, WORD_CNT);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    do_reset();
    OUT_READY = 1'b0;
    for (int w = 0; w < DEPTH + 2; w++) begin
      EN   = 1'b1;
      IN_1 = 8'(w * 16 + 1); IN_2 = 8'(w * 16 + 2);
      IN_3 = 8'(w * 16 + 3); IN_4 = 8'(w * 16 + 4);
      @(negedge CLK);
      if (w == DEPTH) begin
        checks++;
        if ({FULL, OVERFLOW} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL ovf_at_full: got full=%b ovf=%b want full=1 ovf=0", FULL, OVERFLOW);
        end
      end
    end
    EN = 1'b0;
    checks++;
    if ({FULL, OVERFLOW, OUT_VALID, OUT_BYTE} !== {3'b111, 8'h01}) begin
      errors++;
      $display("[TB] FAIL ovf_flags: got full=%b ovf=%b valid=%b byte=%h want 1 1 1 01",
               FULL, OVERFLOW, OUT_VALID, OUT_BYTE);
    end
    OUT_READY = 1'b1;
    for (int w = 0; w < DEPTH + 1; w++) begin
      for (int k = 0; k < 4; k++) begin
        v = 8'(w * 16 + k + 1);
        checks++;
        if ({OUT_VALID, OUT_BYTE} !== {1'b1, v}) begin
          errors++;
          $display("[TB] FAIL ovf_drain[w%0d b%0d]: got valid=%b byte=%h want valid=1 byte=%h",
                   w, k, OUT_VALID, OUT_BYTE, v);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if ({OUT_VALID, FULL, OVERFLOW, CHKSUM, WORD_CNT} !== {3'b001, 8'h04, 8'h05}) begin
      errors++;
      $display("[TB] FAIL ovf_end: got valid=%b full=%b ovf=%b chk=%h cnt=%h want 0 0 1 04 05",
               OUT_VALID, FULL, OVERFLOW, CHKSUM, WORD_CNT);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [3];
    exp = '{8'hAA, 8'hBB, 8'hCC};
    do_reset();
    OUT_READY = 1'b1;
    push_word(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, OUT_BYTE} !== {1'b1, exp[i]}) begin
        errors++;
        $display("[TB] FAIL midrst_byte[%0d]: got valid=%b byte=%h want valid=1 byte=%h",
                 i, OUT_VALID, OUT_BYTE, exp[i]);
      end
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if ({OUT_VALID, OUT_BYTE, CHKSUM, WORD_CNT} !== 25'h0) begin
      errors++;
      $display("[TB] FAIL midrst_clear: got valid=%b byte=%h chk=%h cnt=%h want all 0",
               OUT_VALID, OUT_BYTE, CHKSUM, WORD_CNT);
    end
    @(negedge CLK);
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_no_replay: valid got %b want 0", OUT_VALID);
    end
    push_word(8'h12, 8'h34, 8'h56, 8'h78);
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_BYTE} !== {1'b1, 8'h12}) begin
      errors++;
      $display("[TB] FAIL midrst_next_first: got valid=%b byte=%h want valid=1 byte=12",
               OUT_VALID, OUT_BYTE);
    end
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_BYTE, CHKSUM} !== {1'b1, 8'h34, 8'h12}) begin
      errors++;
      $display("[TB] FAIL midrst_next_second: got valid=%b byte=%h chk=%h want 1 34 12",
               OUT_VALID, OUT_BYTE, CHKSUM);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
